// File: rtl/reg_alu_pkg.sv
// Shared types for the register-file ALU datapath: opcode and sequencer state encodings.
// Opcodes match the 2-bit command bus, so a cmd_op value can be cast directly to op_e.
package reg_alu_pkg;

  localparam logic [1:0] OPC_ADD  = 2'b00;
  localparam logic [1:0] OPC_MUL  = 2'b01;
  localparam logic [1:0] OPC_LOAD = 2'b10;
  localparam logic [1:0] OPC_CLR  = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD  = OPC_ADD,
    OP_MUL  = OPC_MUL,
    OP_LOAD = OPC_LOAD,
    OP_CLR  = OPC_CLR
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

// File: rtl/reg_alu_mul.sv
// Iterative shift-add multiplier: start loads operands, one partial product per cycle.
// Latency WIDTH cycles after start; done marks the final step, prod_lo/ovf are valid alongside it.
module reg_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] sum;

  assign sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end else if (busy_q) begin
      prod_d   = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // Outputs reflect the sum being registered on the final step, so the caller needs no extra cycle.
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LAST);
  assign prod_lo = sum[WIDTH-1:0];
  assign ovf     = |sum[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/reg_alu_datapath.sv
// Register file + constant-operand ALU with IDLE/EXEC/WB sequencer; MUL needs REG_ALU_MUL_EN.
// ADD/LOAD/CLR/error: done 1 cycle after accept, MUL: WIDTH cycles; cmd_ready low outside IDLE.
module reg_alu_datapath
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             ck,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_src,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0] cmd_const,
  input  logic             cmd_cin,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

`ifdef REG_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] src_val_q, src_val_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic             accept;
  logic             src_ok, dst_ok, rd_ok;
  logic             cmd_err;
  logic [WIDTH-1:0] src_rd;
  logic [WIDTH:0]   add_sum;

  assign src_ok  = int'(cmd_src) < NREGS;
  assign dst_ok  = int'(cmd_dst) < NREGS;
  assign rd_ok   = int'(rd_addr) < NREGS;
  assign src_rd  = src_ok ? regs_q[cmd_src] : '0;
  assign rd_data = rd_ok ? regs_q[rd_addr] : '0;
  assign cmd_err = !src_ok || !dst_ok || (!MUL_EN && (cmd_op == OPC_MUL));
  assign accept  = cmd_valid && (state_q == IDLE);
  assign add_sum = {1'b0, src_val_q} + {1'b0, const_q} + {{WIDTH{1'b0}}, cin_q};

`ifdef REG_ALU_MUL_EN
  logic             mul_busy, mul_done, mul_ovf;
  logic [WIDTH-1:0] mul_lo;

  // Started on the accept edge straight from the register file so MUL costs exactly WIDTH cycles.
  reg_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .ck      (ck),
    .clr_n   (clr_n),
    .start   (accept && (cmd_op == OPC_MUL) && !cmd_err),
    .a       (src_rd),
    .b       (cmd_const),
    .busy    (mul_busy),
    .done    (mul_done),
    .prod_lo (mul_lo),
    .ovf     (mul_ovf)
  );
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    const_d   = const_q;
    cin_d     = cin_q;
    src_val_d = src_val_q;
    err_d     = err_q;
    res_d     = res_q;
    cout_d    = cout_q;
    regs_d    = regs_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = op_e'(cmd_op);
          dst_d     = cmd_dst;
          const_d   = cmd_const;
          cin_d     = cmd_cin;
          src_val_d = src_rd;
          err_d     = cmd_err;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // A rejected command only waits out this cycle; result/carry keep their last values.
        if (err_q) begin
          state_d = WB;
        end else begin
          case (op_q)
            OP_ADD: begin
              {cout_d, res_d} = add_sum;
              state_d         = WB;
            end
            OP_MUL: begin
`ifdef REG_ALU_MUL_EN
              if (mul_done) begin
                res_d   = mul_lo;
                cout_d  = mul_ovf;
                state_d = WB;
              end else if (!mul_busy) begin
                state_d = WB;
              end
`else
              state_d = WB;
`endif
            end
            OP_LOAD: begin
              res_d   = const_q;
              cout_d  = 1'b0;
              state_d = WB;
            end
            default: begin
              res_d   = '0;
              cout_d  = 1'b0;
              state_d = WB;
            end
          endcase
        end
      end
      WB: begin
        if (!err_q) regs_d[dst_q] = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      dst_q     <= '0;
      const_q   <= '0;
      cin_q     <= 1'b0;
      src_val_q <= '0;
      err_q     <= 1'b0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      const_q   <= const_d;
      cin_q     <= cin_d;
      src_val_q <= src_val_d;
      err_q     <= err_d;
      res_q     <= res_d;
      cout_q    <= cout_d;
      regs_q    <= regs_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == WB);
  assign err       = (state_q == WB) && err_q;
  assign result    = res_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Directed bench for reg_alu_datapath (WIDTH=8, NREGS=3); expectations follow REG_ALU_MUL_EN.
module tb_reg_alu_datapath;

  logic       ck = 1'b0;
  logic       clr_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [7:0] cmd_const;
  logic       cmd_cin;
  logic       done;
  logic       err;
  logic [7:0] result;
  logic       carry_out;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       d_err;
  logic [7:0] d_res;
  logic       d_c;

`ifdef REG_ALU_MUL_EN
  localparam logic [7:0] PRE_RES = 8'h00;
  localparam logic       PRE_C   = 1'b1;
  localparam logic [7:0] PRE_R0  = 8'h10;
  localparam int         MID_WAIT = 4;
  localparam logic [1:0] MID_OP  = 2'b01;
`else
  localparam logic [7:0] PRE_RES = 8'h10;
  localparam logic       PRE_C   = 1'b0;
  localparam logic [7:0] PRE_R0  = 8'h05;
  localparam int         MID_WAIT = 0;
  localparam logic [1:0] MID_OP  = 2'b00;
`endif

  always #5 ck = ~ck;

  reg_alu_datapath #(.WIDTH(8), .NREGS(3)) dut (
    .ck        (ck),
    .clr_n     (clr_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_const (cmd_const),
    .cmd_cin   (cmd_cin),
    .done      (done),
    .err       (err),
    .result    (result),
    .carry_out (carry_out),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  // Issues one command, returns edges from accept to done (-1 on timeout); ends idle after write-back.
  task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [7:0] k, input logic cin, output int lat);
    int guard = 0;
    lat = -1;
    @(negedge ck);
    while (!cmd_ready && guard < 50) begin
      @(negedge ck);
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_const = k; cmd_cin = cin;
    @(posedge ck); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge ck); #1;
      if (done) begin
        lat = i; d_err = err; d_res = result; d_c = carry_out;
        break;
      end
    end
    @(posedge ck); #1;
  endtask

  task automatic test_reset;
    int lat;
    logic [7:0] v;
    issue(2'b10, 2'd0, 2'd0, 8'h5A, 1'b0, lat);
    issue(2'b10, 2'd0, 2'd1, 8'h3C, 1'b0, lat);
    @(negedge ck); clr_n = 1'b0;
    repeat (2) @(negedge ck);
    clr_n = 1'b1;
    @(posedge ck); #1;
    for (int r = 0; r < 3; r++) begin
      rd(2'(r), v);
      n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_r%0d got %h want 00", r, v); end
    end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
    n_cmp++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry_out); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got %b%b want 00", done, err); end
  endtask

  task automatic test_add;
    int lat;
    logic [7:0] v;
    issue(2'b10, 2'd0, 2'd0, 8'h05, 1'b0, lat);
    n_cmp++; if (lat !== 1 || d_res !== 8'h05) begin n_fail++; $display("FAIL load lat %0d res %h want 1 05", lat, d_res); end
    issue(2'b00, 2'd0, 2'd1, 8'hFF, 1'b0, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL add_lat got %0d want 1", lat); end
    n_cmp++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL add_err got %b want 0", d_err); end
    n_cmp++; if (d_res !== 8'h04 || d_c !== 1'b1) begin n_fail++; $display("FAIL add_ff res %h c %b want 04 1", d_res, d_c); end
    rd(2'd1, v);
    n_cmp++; if (v !== 8'h04) begin n_fail++; $display("FAIL add_ff_r1 got %h want 04", v); end
    issue(2'b00, 2'd0, 2'd1, 8'h0A, 1'b1, lat);
    n_cmp++; if (d_res !== 8'h10 || d_c !== 1'b0) begin n_fail++; $display("FAIL add_cin res %h c %b want 10 0", d_res, d_c); end
    rd(2'd1, v);
    n_cmp++; if (v !== 8'h10) begin n_fail++; $display("FAIL add_cin_r1 got %h want 10", v); end
  endtask

  task automatic test_mul;
    int lat;
    logic [7:0] v;
`ifdef REG_ALU_MUL_EN
    issue(2'b01, 2'd0, 2'd2, 8'h33, 1'b0, lat);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL mul_lat got %0d want 8", lat); end
    n_cmp++; if (d_res !== 8'hFF || d_c !== 1'b0 || d_err !== 1'b0) begin n_fail++; $display("FAIL mul_33 res %h c %b e %b want ff 0 0", d_res, d_c, d_err); end
    rd(2'd2, v);
    n_cmp++; if (v !== 8'hFF) begin n_fail++; $display("FAIL mul_33_r2 got %h want ff", v); end
    issue(2'b10, 2'd0, 2'd0, 8'h10, 1'b0, lat);
    issue(2'b01, 2'd0, 2'd2, 8'h10, 1'b0, lat);
    n_cmp++; if (lat !== 8 || d_res !== 8'h00 || d_c !== 1'b1) begin n_fail++; $display("FAIL mul_ovf lat %0d res %h c %b want 8 00 1", lat, d_res, d_c); end
    rd(2'd2, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL mul_ovf_r2 got %h want 00", v); end
`else
    issue(2'b01, 2'd0, 2'd2, 8'h33, 1'b0, lat);
    n_cmp++; if (lat !== 1 || d_err !== 1'b1) begin n_fail++; $display("FAIL mul_off lat %0d err %b want 1 1", lat, d_err); end
    n_cmp++; if (d_res !== 8'h10 || d_c !== 1'b0) begin n_fail++; $display("FAIL mul_off_hold res %h c %b want 10 0", d_res, d_c); end
    rd(2'd2, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL mul_off_r2 got %h want 00", v); end
`endif
  endtask

  task automatic test_error;
    int lat;
    logic [7:0] v0, v1, v2;
    issue(2'b10, 2'd0, 2'd3, 8'hAA, 1'b0, lat);
    n_cmp++; if (lat !== 1 || d_err !== 1'b1) begin n_fail++; $display("FAIL err_dst lat %0d err %b want 1 1", lat, d_err); end
    n_cmp++; if (d_res !== PRE_RES || d_c !== PRE_C) begin n_fail++; $display("FAIL err_dst_hold res %h c %b want %h %b", d_res, d_c, PRE_RES, PRE_C); end
    rd(2'd0, v0); rd(2'd1, v1); rd(2'd2, v2);
    n_cmp++; if (v0 !== PRE_R0 || v1 !== 8'h10 || v2 !== 8'h00) begin n_fail++; $display("FAIL err_dst_regs got %h %h %h want %h 10 00", v0, v1, v2, PRE_R0); end
    issue(2'b00, 2'd3, 2'd1, 8'h01, 1'b0, lat);
    n_cmp++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL err_src got %b want 1", d_err); end
    rd(2'd1, v1);
    n_cmp++; if (v1 !== 8'h10) begin n_fail++; $display("FAIL err_src_r1 got %h want 10", v1); end
    rd(2'd3, v0);
    n_cmp++; if (v0 !== 8'h00) begin n_fail++; $display("FAIL rd_oob got %h want 00", v0); end
  endtask

  task automatic test_back_to_back;
    @(negedge ck);
    cmd_valid = 1'b1;
    cmd_op = 2'b00; cmd_src = 2'd1; cmd_dst = 2'd1; cmd_const = 8'h01; cmd_cin = 1'b0;
    rd_addr = 2'd1;
    @(posedge ck); #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_exec got %b want 0", cmd_ready); end
    @(posedge ck); #1;
    n_cmp++; if (done !== 1'b1 || cmd_ready !== 1'b0 || result !== 8'h11) begin n_fail++; $display("FAIL b2b_wb1 done %b rdy %b res %h want 1 0 11", done, cmd_ready, result); end
    @(posedge ck); #1;
    n_cmp++; if (cmd_ready !== 1'b1 || rd_data !== 8'h11) begin n_fail++; $display("FAIL b2b_idle rdy %b r1 %h want 1 11", cmd_ready, rd_data); end
    @(posedge ck); #1;
    cmd_valid = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept2 got %b want 0", cmd_ready); end
    @(posedge ck); #1;
    n_cmp++; if (done !== 1'b1 || result !== 8'h12) begin n_fail++; $display("FAIL b2b_wb2 done %b res %h want 1 12", done, result); end
    @(posedge ck); #1;
    n_cmp++; if (rd_data !== 8'h12) begin n_fail++; $display("FAIL b2b_r1 got %h want 12", rd_data); end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    logic seen = 1'b0;
    logic [7:0] v;
    @(negedge ck);
    cmd_valid = 1'b1;
    cmd_op = MID_OP; cmd_src = 2'd1; cmd_dst = 2'd2; cmd_const = 8'h03; cmd_cin = 1'b0;
    @(posedge ck); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < MID_WAIT; i++) begin
      @(posedge ck); #1;
      if (done) seen = 1'b1;
    end
    clr_n = 1'b0;
    repeat (2) begin
      @(posedge ck); #1;
      if (done) seen = 1'b1;
    end
    @(negedge ck); clr_n = 1'b1;
    @(posedge ck); #1;
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_done got %b want 0", seen); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", cmd_ready); end
    for (int r = 0; r < 3; r++) begin
      rd(2'(r), v);
      n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_r%0d got %h want 00", r, v); end
    end
    issue(2'b10, 2'd0, 2'd2, 8'h77, 1'b0, lat);
    n_cmp++; if (lat !== 1 || d_res !== 8'h77 || d_err !== 1'b0) begin n_fail++; $display("FAIL mid_after lat %0d res %h e %b want 1 77 0", lat, d_res, d_err); end
    rd(2'd2, v);
    n_cmp++; if (v !== 8'h77) begin n_fail++; $display("FAIL mid_after_r2 got %h want 77", v); end
  endtask

  initial begin
    clr_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 2'd0; cmd_dst = 2'd0;
    cmd_const = 8'h00; cmd_cin = 1'b0; rd_addr = 2'd0;
    repeat (3) @(negedge ck);
    clr_n = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_error();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
